// File: rtl/slow_memory_arb.sv
// slow_memory_arb: line-organised backing store shared by NUM_CH channels.
// Round-robin grant, fixed LATENCY from grant to a one-cycle ready pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mem_read   per-channel read request (level)
//   mem_write  per-channel write request (level, wins over read)
//   mem_addr   per-channel line address, channel c at [c*ADDR_W +: ADDR_W]
//   mem_wdata  per-channel write line
//   mem_rdata  per-channel registered read line
//   mem_ready  per-channel one-cycle completion pulse
//   busy       high while a transaction is in BUSY or RESP
module slow_memory_arb #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 28,
    parameter int IDX_W   = 8,
    parameter int LATENCY = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        mem_read,
    input  logic [NUM_CH-1:0]        mem_write,
    input  logic [NUM_CH*ADDR_W-1:0] mem_addr,
    input  logic [NUM_CH*LINE_W-1:0] mem_wdata,
    output logic [NUM_CH*LINE_W-1:0] mem_rdata,
    output logic [NUM_CH-1:0]        mem_ready,
    output logic                     busy
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    logic [LINE_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   gnt_ch_q;
    logic              op_wr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_CH-1:0] req;
    logic              arb_hit;
    logic [CH_W-1:0]   arb_ch;
    logic [ADDR_W-1:0] arb_addr;
    logic [LINE_W-1:0] arb_wdata;
    logic              arb_wr;
    logic              grant;
    logic [CH_W-1:0]   rr_next;

    logic              load_en;
    logic [CH_W-1:0]   load_ch;
    logic [IDX_W-1:0]  load_idx;

    // Upper line-address bits alias onto the array and are ignored.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^arb_addr;

    assign req = mem_read | mem_write;

    // Walk from the farthest offset down so the channel nearest
    // rr_ptr is the last (winning) assignment.
    always_comb begin
        arb_hit = 1'b0;
        arb_ch  = rr_ptr_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            int c;
            c = int'(rr_ptr_q) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (req[c]) begin
                arb_hit = 1'b1;
                arb_ch  = CH_W'(c);
            end
        end
    end

    assign arb_addr  = mem_addr[arb_ch*ADDR_W +: ADDR_W];
    assign arb_wdata = mem_wdata[arb_ch*LINE_W +: LINE_W];
    assign arb_wr    = mem_write[arb_ch];

    assign rr_next = (gnt_ch_q == CH_W'(NUM_CH - 1)) ?
                     '0 : gnt_ch_q + CH_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant   = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With a single-cycle latency the read data is captured at the
    // grant edge itself, straight from the arbitration mux.
    always_comb begin
        if (LATENCY == 1) begin
            load_en  = grant && !arb_wr;
            load_ch  = arb_ch;
            load_idx = arb_addr[IDX_W-1:0];
        end else begin
            load_en  = (state_q == BUSY) && (cnt_q == CNT_W'(1)) && !op_wr_q;
            load_ch  = gnt_ch_q;
            load_idx = idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_ch_q  <= '0;
            op_wr_q   <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            mem_rdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                gnt_ch_q <= arb_ch;
                op_wr_q  <= arb_wr;
                idx_q    <= arb_addr[IDX_W-1:0];
            end
            if (state_q == RESP) rr_ptr_q <= rr_next;
            if (load_en) mem_rdata[load_ch*LINE_W +: LINE_W] <= mem[load_idx];
        end
    end

    // Writes commit at the grant edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst_n && grant && arb_wr) mem[arb_addr[IDX_W-1:0]] <= arb_wdata;
    end

    always_comb begin
        mem_ready = '0;
        if (state_q == RESP) mem_ready[gnt_ch_q] = 1'b1;
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_slow_memory_arb.sv
// tb_slow_memory_arb: directed bench for slow_memory_arb.
// Default 2-channel LATENCY=5 instance plus a 4-channel LATENCY=1 instance.
module tb_slow_memory_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [1:0]   rd_a = '0;
    logic [1:0]   wr_a = '0;
    logic [55:0]  addr_a = '0;
    logic [255:0] wdata_a = '0;
    logic [255:0] rdata_a;
    logic [1:0]   rdy_a;
    logic         busy_a;

    logic [3:0]   rd_b = '0;
    logic [3:0]   wr_b = '0;
    logic [31:0]  addr_b = '0;
    logic [63:0]  wdata_b = '0;
    logic [63:0]  rdata_b;
    logic [3:0]   rdy_b;
    logic         busy_b;

    slow_memory_arb u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (rd_a),
        .mem_write (wr_a),
        .mem_addr  (addr_a),
        .mem_wdata (wdata_a),
        .mem_rdata (rdata_a),
        .mem_ready (rdy_a),
        .busy      (busy_a)
    );

    slow_memory_arb #(
        .NUM_CH  (4),
        .LINE_W  (16),
        .ADDR_W  (8),
        .IDX_W   (4),
        .LATENCY (1)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (rd_b),
        .mem_write (wr_b),
        .mem_addr  (addr_b),
        .mem_wdata (wdata_b),
        .mem_rdata (rdata_b),
        .mem_ready (rdy_b),
        .busy      (busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_1  = 128'h1111_0000_0000_0001;
    localparam logic [127:0] D_2  = 128'h2222_0000_0000_0002;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic rd, input logic wr,
                         input logic [27:0] a, input logic [127:0] d);
        rd_a[ch] = rd;
        wr_a[ch] = wr;
        addr_a[ch*28 +: 28] = a;
        wdata_a[ch*128 +: 128] = d;
    endtask

    task automatic set_b(input int ch, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [15:0] d);
        rd_b[ch] = rd;
        wr_b[ch] = wr;
        addr_b[ch*8 +: 8] = a;
        wdata_b[ch*16 +: 16] = d;
    endtask

    // Counts edges from the next one until a ready pulse is seen.
    task automatic wait_a(input int ch, input int exp_n, input string tag);
        int n;
        logic [1:0] oh;
        n = 0;
        oh = 2'b01 << ch;
        do begin
            step();
            n++;
        end while (rdy_a === 2'b00 && n < 40);
        chk({tag, ".lat"}, 128'(n), 128'(exp_n));
        chk({tag, ".rdy"}, 128'(rdy_a), 128'(oh));
        chk({tag, ".busy"}, 128'(busy_a), 128'(1));
    endtask

    task automatic wait_b(input int ch, input int exp_n, input string tag);
        int n;
        logic [3:0] oh;
        n = 0;
        oh = 4'b0001 << ch;
        do begin
            step();
            n++;
        end while (rdy_b === 4'b0000 && n < 40);
        chk({tag, ".lat"}, 128'(n), 128'(exp_n));
        chk({tag, ".rdy"}, 128'(rdy_b), 128'(oh));
    endtask

    task automatic txn_a(input int ch, input logic wr, input logic [27:0] a,
                         input logic [127:0] d, input string tag);
        set_a(ch, !wr, wr, a, d);
        wait_a(ch, 5, tag);
        set_a(ch, 1'b0, 1'b0, '0, '0);
        step();
        chk({tag, ".idle"}, 128'(busy_a), 128'(0));
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        step();
        step();
        chk("rst.rdy_a", 128'(rdy_a), 128'(0));
        chk("rst.busy_a", 128'(busy_a), 128'(0));
        chk("rst.rdata_a", rdata_a[127:0], 128'(0));
        chk("rst.rdata_a1", rdata_a[255:128], 128'(0));
        chk("rst.rdy_b", 128'(rdy_b), 128'(0));
        chk("rst.rdata_b", 128'(rdata_b), 128'(0));
        rst_n = 1'b1;
        step();

        // Preload line 3 via ch1, then ch0 reads it
        txn_a(1, 1'b1, 28'd3, D_A5, "pre3");
        chk("pre3.rd1", rdata_a[255:128], 128'(0));
        txn_a(0, 1'b0, 28'd3, '0, "rd3");
        chk("rd3.data0", rdata_a[127:0], D_A5);
        chk("rd3.data1", rdata_a[255:128], 128'(0));

        // Preload lines 1 and 2
        txn_a(1, 1'b1, 28'd1, D_1, "pre1");
        txn_a(1, 1'b1, 28'd2, D_2, "pre2");

        // Simultaneous reads with rr_ptr=0
        set_a(0, 1'b1, 1'b0, 28'd1, '0);
        set_a(1, 1'b1, 1'b0, 28'd2, '0);
        wait_a(0, 5, "pair1.ch0");
        chk("pair1.d0", rdata_a[127:0], D_1);
        set_a(0, 1'b0, 1'b0, '0, '0);
        wait_a(1, 6, "pair1.ch1");
        chk("pair1.d1", rdata_a[255:128], D_2);
        chk("pair1.d0h", rdata_a[127:0], D_1);
        set_a(1, 1'b0, 1'b0, '0, '0);
        step();

        // Repeat with addresses swapped, rr_ptr back at 0
        set_a(0, 1'b1, 1'b0, 28'd2, '0);
        set_a(1, 1'b1, 1'b0, 28'd1, '0);
        wait_a(0, 5, "pair2.ch0");
        chk("pair2.d0", rdata_a[127:0], D_2);
        set_a(0, 1'b0, 1'b0, '0, '0);
        wait_a(1, 6, "pair2.ch1");
        chk("pair2.d1", rdata_a[255:128], D_1);
        set_a(1, 1'b0, 1'b0, '0, '0);
        step();

        // rr_ptr=1 after a lone ch0 grant: ch1 must win next
        txn_a(0, 1'b0, 28'd3, '0, "solo0");
        set_a(0, 1'b1, 1'b0, 28'd1, '0);
        set_a(1, 1'b1, 1'b0, 28'd3, '0);
        wait_a(1, 5, "rr1.ch1");
        chk("rr1.d1", rdata_a[255:128], D_A5);
        chk("rr1.d0", rdata_a[127:0], D_A5);
        set_a(1, 1'b0, 1'b0, '0, '0);
        wait_a(0, 6, "rr1.ch0");
        chk("rr1.d0b", rdata_a[127:0], D_1);
        set_a(0, 1'b0, 1'b0, '0, '0);
        step();

        // Cross-channel coherence
        txn_a(1, 1'b1, 28'd7, 128'h1234, "coh.wr");
        txn_a(0, 1'b0, 28'd7, '0, "coh.rd");
        chk("coh.d0", rdata_a[127:0], 128'h1234);

        // Address wrap, read+write together counts as write
        set_a(0, 1'b1, 1'b1, 28'h105, 128'hBEEF);
        wait_a(0, 5, "wrap.wr");
        chk("wrap.wr.d0", rdata_a[127:0], 128'h1234);
        set_a(0, 1'b0, 1'b0, '0, '0);
        step();
        txn_a(1, 1'b0, 28'h005, '0, "wrap.rd");
        chk("wrap.d1", rdata_a[255:128], 128'hBEEF);

        // Reset right after a write grant: write stays committed
        set_a(1, 1'b0, 1'b1, 28'd9, 128'h99);
        step();
        chk("rstw.busy", 128'(busy_a), 128'(1));
        rst_n = 1'b0;
        set_a(1, 1'b0, 1'b0, '0, '0);
        step();
        chk("rstw.rdy", 128'(rdy_a), 128'(0));
        chk("rstw.busy0", 128'(busy_a), 128'(0));
        rst_n = 1'b1;
        step();

        // Reset in cycle 3 of a read: aborted, no ready
        set_a(0, 1'b1, 1'b0, 28'd3, '0);
        step();
        step();
        chk("rstr.c1.rdy", 128'(rdy_a), 128'(0));
        step();
        chk("rstr.c2.rdy", 128'(rdy_a), 128'(0));
        rst_n = 1'b0;
        set_a(0, 1'b0, 1'b0, '0, '0);
        step();
        chk("rstr.rdy", 128'(rdy_a), 128'(0));
        chk("rstr.busy", 128'(busy_a), 128'(0));
        chk("rstr.rdata", rdata_a[127:0], 128'(0));
        rst_n = 1'b1;
        step();
        step();
        chk("rstr.norsp", 128'(rdy_a), 128'(0));
        txn_a(0, 1'b0, 28'd9, '0, "rstw.rd");
        chk("rstw.d0", rdata_a[127:0], 128'h99);

        // 4 channels, LATENCY=1: writes from all at once
        for (int c = 0; c < 4; c++) set_b(c, 1'b0, 1'b1, 8'(c), 16'h1000 + 16'(c));
        for (int c = 0; c < 4; c++) begin
            wait_b(c, (c == 0) ? 1 : 2, $sformatf("b.wr%0d", c));
            set_b(c, 1'b0, 1'b0, '0, '0);
        end
        step();
        chk("b.idle", 128'(busy_b), 128'(0));

        // All four read the next channel's line
        for (int c = 0; c < 4; c++) set_b(c, 1'b1, 1'b0, 8'((c + 1) % 4), '0);
        for (int c = 0; c < 4; c++) begin
            logic [15:0] exp_d;
            exp_d = 16'h1000 + 16'((c + 1) % 4);
            wait_b(c, (c == 0) ? 1 : 2, $sformatf("b.rd%0d", c));
            chk($sformatf("b.rd%0d.d", c), 128'(rdata_b[c*16 +: 16]),
                128'(exp_d));
            set_b(c, 1'b0, 1'b0, '0, '0);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
